// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer slice.
package core_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int PC_INC       = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_TRAP   = 3'd6
   } core_state_e;

endpackage

// File: rtl/instret_counter.sv
// Wrap-around retired-instruction counter with increment enable and async clear.
module instret_counter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_r;

   // Count up by one per enabled cycle; all-ones rolls over to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer owning the PC,
// the instruction register, halt handling and the illegal-instruction trap.
module core_seq
   import core_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] inst,
   output logic            inst_valid,
   input  logic            dec_wen,
   input  logic            dec_illegal,
   output logic            rf_wen,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instret,
   input  logic            halt_req,
   output logic            halted,
   output logic            trap
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

   core_state_e     state_r;
   core_state_e     state_next_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] inst_r;
   logic            retire_s;
   logic            imem_req_valid_r;
   logic            inst_valid_r;
   logic            rf_wen_r;
   logic            halted_r;
   logic            trap_r;

   // Next-state selection; halt_req and imem_rsp_valid only matter in WB/HALT and WAIT.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH: begin
            if (imem_req_valid_r && imem_req_ready) state_next_s = ST_WAIT;
            else                                    state_next_s = ST_FETCH;
         end
         ST_WAIT: begin
            if (imem_rsp_valid) state_next_s = ST_DECODE;
            else                state_next_s = ST_WAIT;
         end
         ST_DECODE: begin
            if (dec_illegal) state_next_s = ST_TRAP;
            else             state_next_s = ST_EXEC;
         end
         ST_EXEC:  state_next_s = ST_WB;
         ST_WB, ST_HALT: begin
            if (halt_req) state_next_s = ST_HALT;
            else          state_next_s = ST_FETCH;
         end
         ST_TRAP:  state_next_s = ST_TRAP;
         default:  state_next_s = ST_FETCH;
      endcase
   end

   assign retire_s = (state_r == ST_WB);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_FETCH;
      else      state_r <= state_next_s;
   end

   // PC advances only when an instruction retires, so a trapped PC stays at the fault.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          pc_r <= RESET_PC;
      else if (retire_s) pc_r <= pc_r + PC_STEP;
      else               pc_r <= pc_r;
   end

   // Instruction register: responses are only accepted while waiting for one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    inst_r <= '0;
      else if (state_r == ST_WAIT && imem_rsp_valid) inst_r <= imem_rsp_data;
      else                                         inst_r <= inst_r;
   end

   // Output flags are registered from the next state so they line up with state_r.
   // rf_wen captures dec_wen on entry to WB; decode holds it stable while inst is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imem_req_valid_r <= 1'b0;
         inst_valid_r     <= 1'b0;
         rf_wen_r         <= 1'b0;
         halted_r         <= 1'b0;
         trap_r           <= 1'b0;
      end else begin
         imem_req_valid_r <= (state_next_s == ST_FETCH);
         inst_valid_r     <= (state_next_s == ST_DECODE) || (state_next_s == ST_EXEC);
         rf_wen_r         <= (state_next_s == ST_WB) && dec_wen;
         halted_r         <= (state_next_s == ST_HALT);
         trap_r           <= (state_next_s == ST_TRAP);
      end
   end

   instret_counter #(.WIDTH(XLEN)) u_instret (
      .clk   (clk),
      .rst_n (rst),
      .en    (retire_s),
      .count (instret)
   );

   assign imem_req_valid = imem_req_valid_r;
   assign imem_req_addr  = pc_r;
   assign pc             = pc_r;
   assign inst           = inst_r;
   assign inst_valid     = inst_valid_r;
   assign rf_wen         = rf_wen_r;
   assign halted         = halted_r;
   assign trap           = trap_r;

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle sequencer for the single-issue core datapath. It owns the program counter, issues instruction fetches over a valid/ready request channel, and steps decode, execute and writeback one instruction at a time. It gates the register-file write enable, counts retired instructions, and handles halt requests and illegal-instruction traps. It sits between instruction memory and the decode/regfile/ALU path and replaces the free-running `pc + 4` update.

## Interface
- XLEN, 64, datapath, PC and instruction width
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (rst = 0 resets)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request when valid && ready
- imem_req_addr  out  XLEN  fetch address, equal to pc
- imem_rsp_valid  in  1  fetch data valid, one-cycle pulse
- imem_rsp_data  in  XLEN  fetched instruction
- inst  out  XLEN  captured instruction held for decode
- inst_valid  out  1  high in DECODE and EXEC
- dec_wen  in  1  decode's write-enable for the current instruction
- dec_illegal  in  1  decode flags the instruction illegal, sampled in DECODE
- rf_wen  out  1  gated regfile write enable, equal to dec_wen in WB only
- pc  out  XLEN  architectural PC of the current instruction
- instret  out  XLEN  retired-instruction count
- halt_req  in  1  level request to stop at the next instruction boundary
- halted  out  1  high in HALT
- trap  out  1  high in TRAP; sticky until reset

## Operation
- States: FETCH, WAIT, DECODE, EXEC, WB, HALT, TRAP.
- FETCH:
  - imem_req_valid = 1.
  - On valid && ready, go to WAIT.
  - imem_req_addr stays stable while stalled.
- WAIT:
  - On imem_rsp_valid, capture imem_rsp_data into inst and go to DECODE.
  - With no response, remain in WAIT indefinitely.
- DECODE:
  - If dec_illegal = 1, go to TRAP. pc stays at the faulting address and no retire occurs.
  - Otherwise go to EXEC.
- EXEC: one cycle for ALU settle, then go to WB.
- WB:
  - rf_wen = dec_wen.
  - pc <= pc + 4, modulo 2^XLEN.
  - instret <= instret + 1; wraps from all-ones to 0.
  - Next state is HALT if halt_req = 1, else FETCH.
- HALT:
  - All request and enable outputs are 0.
  - Return to FETCH on the first cycle halt_req = 0.
- TRAP: all request and enable outputs are 0; only reset exits.
- imem_rsp_valid outside WAIT is ignored.
- halt_req outside WB is ignored; halt takes effect only after a retire.
- Reset in any state, including mid-fetch:
  - State goes to FETCH, pc = RESET_PC, instret = 0, inst = 0.
  - A late response from a pre-reset request arrives outside WAIT and is dropped.

## Timing
- Reset values:
  - imem_req_valid = 0 while rst = 0; it becomes 1 on the first cycle after release.
  - inst_valid = 0, rf_wen = 0, halted = 0, trap = 0.
  - pc = imem_req_addr = RESET_PC, instret = 0, inst = 0.
- All outputs are registered state or decoded from state only; there are no combinational input-to-output paths except none.
- Best case: ready on the first FETCH cycle and response one cycle after accept gives 5 cycles per instruction (FETCH, WAIT, DECODE, EXEC, WB).
- Every FETCH-cycle stall adds 1 cycle, and every WAIT-cycle delay adds 1 cycle.
- pc and instret update on the edge leaving WB. The new pc is visible in the next FETCH.
- Same-cycle halt_req = 1 with WB: the instruction retires, then the block enters HALT. halted rises one cycle after WB.

## Structure
- core_pkg holds:
  - the state enum `core_state_e` (7 states, 3-bit encoding);
  - the XLEN default;
  - the PC increment constant (4).
- core_seq uses one registered state and a combinational next-state block.
- One sub-module is natural: `instret_counter`, an XLEN-wide wrap-around counter with increment enable and async active-low clear.

## Test plan
- Reset release, RESET_PC = 0x0, ready = 1, response after 1 cycle, dec_wen = 1 → first instruction retires at cycle 5 with rf_wen pulsing once; pc = 0x4 and instret = 1 afterwards.
- imem_req_ready low for 3 cycles in FETCH → imem_req_valid and imem_req_addr are held constant; retire occurs at cycle 8.
- dec_illegal = 1 on the second instruction (pc = 0x4) → trap = 1, pc stays 0x4, instret = 1, imem_req_valid = 0 for 20 or more cycles.
- halt_req raised during EXEC of instruction 0 → instruction 0 retires, halted = 1; deasserting halt_req resumes fetch at 0x4.
- rst asserted in WAIT, with the stale imem_rsp_valid arriving after release while the block is in FETCH → the response is ignored, pc = RESET_PC, instret = 0.
- Preload instret = all-ones through a forced state and retire once → instret = 0; pc at 0xFFFF_FFFF_FFFF_FFFC retires to 0x0.
